multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Main control FSM of the 16-bit multicycle processor; initiator side of the ALUOp interface.
- Sequences fetch/decode/execute/memory/writeback per instruction and drives datapath enables and mux selects.
- Drives alu_op[1:0] to the ALU control decoder (00 add, 01 sub, 10 R-type funct, 11 addi/add).
- Supports a memory wait-state handshake and counts retired instructions.

Parameters:
- CNT_W, 16, width of retired-instruction counter

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- opcode  in  4  instruction register bits [15:12]
- mem_ready  in  1  memory access completes this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load
- mem_to_reg  out  1  register write data: 0 = ALUOut, 1 = MDR
- reg_dst  out  1  destination register: 0 = rt, 1 = rd
- reg_write  out  1  register file write enable
- alu_src_a  out  1  ALU A: 0 = PC, 1 = regA
- alu_src_b  out  2  ALU B: 00 regB, 01 increment constant, 10 sign-extended immediate, 11 branch offset
- alu_op  out  2  to ALU control decoder
- pc_source  out  2  PC source: 00 ALU result, 01 ALUOut, 10 jump target
- state_dbg  out  4  current state encoding
- halted  out  1  in HALT state
- retired  out  CNT_W  retired-instruction count

Behaviour:
- Synchronous active-high reset, clocked on clock. While reset=1 at an edge, next state is IDLE and retired becomes 0.
- IDLE: all outputs 0. IDLE always goes to FETCH on the next clock.
- Outputs are a combinational function of state. Exception: ir_write and pc_write in FETCH, which are additionally ANDed with mem_ready.
- Any output not listed for a state is 0.
- Opcodes: 0000 RTYPE, 0001 LW, 0010 SW, 0011 BEQ, 0100 ADDI, 0101 J. Any other value is illegal.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00, ir_write=pc_write=mem_ready. Holds while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode: LW/SW to MEMADR, RTYPE to EXECUTE, BEQ to BRANCH, ADDI to ADDI_EX, J to JUMP, illegal to HALT.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEMREAD on LW, MEMWRITE on SW.
- MEMREAD: mem_read=1, i_or_d=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Goes to FETCH.
- MEMWRITE: mem_write=1, i_or_d=1. Waits for mem_ready, then goes to FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. Goes to ALUWB.
- ALUWB: reg_write=1, reg_dst=1. Goes to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Goes to FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=11. Goes to ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Goes to FETCH.
- JUMP: pc_write=1, pc_source=10. Goes to FETCH.
- HALT: halted=1, all other outputs 0. Exits only via reset.
- Cycle counts with mem_ready=1 throughout:
  - LW 5; SW 4; RTYPE 4; ADDI 4; BEQ 3; J 3.
  - Each mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- retired increments by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB, BRANCH, ADDI_WB or JUMP.
  - Not from IDLE.
  - Wraps modulo 2^CNT_W.
- Reset mid-instruction, including during a memory wait, aborts the instruction: no further enables and no count.
- opcode is sampled only in DECODE and MEMADR and must be stable from IR after FETCH.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - state encodings, 4-bit: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMREAD=4, MEMWB=5, MEMWRITE=6, EXECUTE=7, ALUWB=8, BRANCH=9, ADDI_EX=10, ADDI_WB=11, JUMP=12, HALT=15;
  - opcode constants;
  - ALUOP_ADD/SUB/RTYPE/ADDI;
  - alu_src_b and pc_source select constants.
- Single module, no sub-module; the counter is inline.

Test Plan:
- Reset held 2 cycles, then released, then LW with mem_ready=1 → state sequence 0,1,2,3,4,5,1; MEMWB asserts reg_write=1, mem_to_reg=1; retired=1.
- RTYPE with mem_ready=1 → 1,2,7,8,1; EXECUTE asserts alu_op=10; ALUWB asserts reg_dst=1, reg_write=1; retired increments.
- FETCH with mem_ready=0 for 3 cycles, then 1 → stays in state 1 with mem_read=1, ir_write=0, pc_write=0 for 3 cycles; single ir_write/pc_write pulse on the 4th cycle.
- SW with MEMWRITE mem_ready=0 for 2 cycles → mem_write=1, i_or_d=1 held for 3 cycles total; mem_write never asserted in any other state.
- BEQ then J → BRANCH shows alu_op=01, pc_write_cond=1, pc_source=01; JUMP shows pc_write=1, pc_source=10; retired +2.
- Opcode 1111, then reset asserted in MEMREAD on a later LW → HALT with halted=1 persisting 10 cycles; reset returns to IDLE with retired=0 and all enables 0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the multicycle processor control path: FSM state
// encodings, opcode values, ALUOp codes and datapath mux select values.
package cpu_ctrl_pkg;

    // FSM state encodings (4-bit, visible on state_dbg)
    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_FETCH    = 4'd1;
    localparam logic [3:0] ST_DECODE   = 4'd2;
    localparam logic [3:0] ST_MEMADR   = 4'd3;
    localparam logic [3:0] ST_MEMREAD  = 4'd4;
    localparam logic [3:0] ST_MEMWB    = 4'd5;
    localparam logic [3:0] ST_MEMWRITE = 4'd6;
    localparam logic [3:0] ST_EXECUTE  = 4'd7;
    localparam logic [3:0] ST_ALUWB    = 4'd8;
    localparam logic [3:0] ST_BRANCH   = 4'd9;
    localparam logic [3:0] ST_ADDI_EX  = 4'd10;
    localparam logic [3:0] ST_ADDI_WB  = 4'd11;
    localparam logic [3:0] ST_JUMP     = 4'd12;
    localparam logic [3:0] ST_HALT     = 4'd15;

    // Instruction opcodes (IR[15:12])
    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_LW    = 4'b0001;
    localparam logic [3:0] OP_SW    = 4'b0010;
    localparam logic [3:0] OP_BEQ   = 4'b0011;
    localparam logic [3:0] OP_ADDI  = 4'b0100;
    localparam logic [3:0] OP_J     = 4'b0101;

    // ALUOp codes sent to the ALU control decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ADDI  = 2'b11;

    // ALU B operand select
    localparam logic [1:0] SRCB_REGB = 2'b00;
    localparam logic [1:0] SRCB_INC  = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFS = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // True for the final state of every instruction; leaving it for FETCH
    // retires that instruction.
    function automatic logic is_retire_state(input logic [3:0] st);
        logic r;
        case (st)
            ST_MEMWB, ST_MEMWRITE, ST_ALUWB,
            ST_BRANCH, ST_ADDI_WB, ST_JUMP: r = 1'b1;
            default:                        r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM of the 16-bit multicycle processor. Sequences each
// instruction through fetch/decode/execute/memory/writeback, drives the
// datapath enables and mux selects, and counts retired instructions.
module multicycle_control
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic [3:0]       state_dbg,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    logic [3:0]       state_r;
    logic [3:0]       next_state_s;
    logic [CNT_W-1:0] retired_r;
    logic             retire_s;

    // Next-state selection; unused encodings fall into HALT so a corrupted
    // state can never issue datapath enables again until reset.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE:  next_state_s = ST_FETCH;
            ST_FETCH: begin
                if (mem_ready) next_state_s = ST_DECODE;
                else           next_state_s = ST_FETCH;
            end
            ST_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: next_state_s = ST_MEMADR;
                    OP_RTYPE:     next_state_s = ST_EXECUTE;
                    OP_BEQ:       next_state_s = ST_BRANCH;
                    OP_ADDI:      next_state_s = ST_ADDI_EX;
                    OP_J:         next_state_s = ST_JUMP;
                    default:      next_state_s = ST_HALT;
                endcase
            end
            ST_MEMADR: begin
                case (opcode)
                    OP_LW:   next_state_s = ST_MEMREAD;
                    OP_SW:   next_state_s = ST_MEMWRITE;
                    default: next_state_s = ST_HALT;
                endcase
            end
            ST_MEMREAD: begin
                if (mem_ready) next_state_s = ST_MEMWB;
                else           next_state_s = ST_MEMREAD;
            end
            ST_MEMWB: next_state_s = ST_FETCH;
            ST_MEMWRITE: begin
                if (mem_ready) next_state_s = ST_FETCH;
                else           next_state_s = ST_MEMWRITE;
            end
            ST_EXECUTE: next_state_s = ST_ALUWB;
            ST_ALUWB:   next_state_s = ST_FETCH;
            ST_BRANCH:  next_state_s = ST_FETCH;
            ST_ADDI_EX: next_state_s = ST_ADDI_WB;
            ST_ADDI_WB: next_state_s = ST_FETCH;
            ST_JUMP:    next_state_s = ST_FETCH;
            ST_HALT:    next_state_s = ST_HALT;
            default:    next_state_s = ST_HALT;
        endcase
    end

    // An instruction retires when its last state hands control back to FETCH.
    always_comb begin
        if ((next_state_s == ST_FETCH) && is_retire_state(state_r)) retire_s = 1'b1;
        else                                                       retire_s = 1'b0;
    end

    // State register with synchronous reset back to IDLE.
    always_ff @(posedge clock) begin
        if (reset) state_r <= ST_IDLE;
        else       state_r <= next_state_s;
    end

    // Retired-instruction counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clock) begin
        if (reset)         retired_r <= {CNT_W{1'b0}};
        else if (retire_s) retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
        else               retired_r <= retired_r;
    end

    // Datapath control decode: Moore outputs, except the FETCH-state IR/PC
    // loads which must wait for the instruction word to arrive.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REGB;
        alu_op        = ALUOP_ADD;
        pc_source     = PCSRC_ALU;
        halted        = 1'b0;
        case (state_r)
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_INC;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            ST_DECODE: begin
                alu_src_b = SRCB_BOFS;
            end
            ST_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            ST_MEMREAD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            ST_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            ST_MEMWRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            ST_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_RTYPE;
            end
            ST_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
            end
            ST_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_ADDI;
            end
            ST_ADDI_WB: begin
                reg_write = 1'b1;
            end
            ST_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                halted = 1'b0;
            end
        endcase
    end

    assign state_dbg = state_r;
    assign retired   = retired_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. A reference model expands each
// instruction (opcode plus chosen wait-state counts) into the list of states
// it must visit, and a per-state table gives the expected control word.
module tb_multicycle_control;

    localparam int CNT_W = 4;
    localparam int CNT_MOD = 16;

    // Bench-side state numbering (independent of the RTL package)
    localparam logic [3:0] S_IDLE = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2,
                           S_MEMADR = 4'd3, S_MEMREAD = 4'd4, S_MEMWB = 4'd5,
                           S_MEMWRITE = 4'd6, S_EXECUTE = 4'd7, S_ALUWB = 4'd8,
                           S_BRANCH = 4'd9, S_ADDI_EX = 4'd10, S_ADDI_WB = 4'd11,
                           S_JUMP = 4'd12, S_HALT = 4'd15;

    logic clock = 1'b0;
    logic reset;
    logic [3:0] opcode;
    logic mem_ready;
    logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic mem_to_reg, reg_dst, reg_write, alu_src_a, halted;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state_dbg;
    logic [CNT_W-1:0] retired;

    int checks = 0;
    int errors = 0;
    int exp_retired = 0;

    typedef struct packed {
        logic [3:0] st;
        logic       mr;
        logic [3:0] op;
        logic       last;
    } step_t;

    step_t sq[$];

    multicycle_control #(.CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .state_dbg(state_dbg), .halted(halted),
        .retired(retired)
    );

    always #5 clock = ~clock;

    // Control word: {pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
    // ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
    // alu_op, pc_source, halted}
    function automatic logic [16:0] exp_ctrl(input logic [3:0] st, input logic mr);
        logic pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, asa, hl;
        logic [1:0] bs, aop, ps;
        {pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, asa, hl} = 11'b0;
        bs = 2'b00; aop = 2'b00; ps = 2'b00;
        case (st)
            S_FETCH:    begin mrd = 1'b1; bs = 2'b01; irw = mr; pw = mr; end
            S_DECODE:   begin bs = 2'b11; end
            S_MEMADR:   begin asa = 1'b1; bs = 2'b10; end
            S_MEMREAD:  begin mrd = 1'b1; iod = 1'b1; end
            S_MEMWB:    begin rw = 1'b1; m2r = 1'b1; end
            S_MEMWRITE: begin mwr = 1'b1; iod = 1'b1; end
            S_EXECUTE:  begin asa = 1'b1; aop = 2'b10; end
            S_ALUWB:    begin rw = 1'b1; rd = 1'b1; end
            S_BRANCH:   begin asa = 1'b1; aop = 2'b01; pwc = 1'b1; ps = 2'b01; end
            S_ADDI_EX:  begin asa = 1'b1; bs = 2'b10; aop = 2'b11; end
            S_ADDI_WB:  begin rw = 1'b1; end
            S_JUMP:     begin pw = 1'b1; ps = 2'b10; end
            S_HALT:     begin hl = 1'b1; end
            default:    begin hl = 1'b0; end
        endcase
        return {pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, asa, bs, aop, ps, hl};
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expand one instruction into its expected state sequence.
    task automatic add_instr(input logic [3:0] op, input int fwait, input int mwait);
        step_t s;
        s.op = op; s.last = 1'b0;
        for (int i = 0; i < fwait; i++) begin s.st = S_FETCH; s.mr = 1'b0; sq.push_back(s); end
        s.st = S_FETCH;  s.mr = 1'b1;      sq.push_back(s);
        s.st = S_DECODE; s.mr = rnd_bit(); sq.push_back(s);
        case (op)
            4'd1: begin
                s.st = S_MEMADR; s.mr = rnd_bit(); sq.push_back(s);
                for (int i = 0; i < mwait; i++) begin s.st = S_MEMREAD; s.mr = 1'b0; sq.push_back(s); end
                s.st = S_MEMREAD; s.mr = 1'b1; sq.push_back(s);
                s.st = S_MEMWB; s.mr = rnd_bit(); s.last = 1'b1; sq.push_back(s);
            end
            4'd2: begin
                s.st = S_MEMADR; s.mr = rnd_bit(); sq.push_back(s);
                for (int i = 0; i < mwait; i++) begin s.st = S_MEMWRITE; s.mr = 1'b0; sq.push_back(s); end
                s.st = S_MEMWRITE; s.mr = 1'b1; s.last = 1'b1; sq.push_back(s);
            end
            4'd0: begin
                s.st = S_EXECUTE; s.mr = rnd_bit(); sq.push_back(s);
                s.st = S_ALUWB; s.mr = rnd_bit(); s.last = 1'b1; sq.push_back(s);
            end
            4'd3: begin s.st = S_BRANCH; s.mr = rnd_bit(); s.last = 1'b1; sq.push_back(s); end
            4'd4: begin
                s.st = S_ADDI_EX; s.mr = rnd_bit(); sq.push_back(s);
                s.st = S_ADDI_WB; s.mr = rnd_bit(); s.last = 1'b1; sq.push_back(s);
            end
            4'd5: begin s.st = S_JUMP; s.mr = rnd_bit(); s.last = 1'b1; sq.push_back(s); end
            default: begin s.st = S_HALT; s.mr = rnd_bit(); sq.push_back(s); end
        endcase
    endtask

    // Drive one cycle's inputs at the falling edge and check the outputs.
    task automatic check_cycle(input logic [3:0] st, input logic mr, input logic [3:0] op,
                               input logic rst, input string tag);
        logic [16:0] obs;
        logic [16:0] exp;
        @(negedge clock);
        reset = rst; mem_ready = mr; opcode = op;
        #1;
        obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, halted};
        exp = exp_ctrl(st, mr);
        checks += 3;
        assert (state_dbg === st) else begin
            errors++;
            $error("FAIL %s state observed=%0d expected=%0d", tag, state_dbg, st);
        end
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s ctrl(state %0d) observed=%b expected=%b", tag, st, obs, exp);
        end
        assert (retired === CNT_W'(exp_retired)) else begin
            errors++;
            $error("FAIL %s retired observed=%0d expected=%0d", tag, retired, exp_retired);
        end
    endtask

    // Consume the queued expected steps, advancing the retire model.
    task automatic run_queue(input string tag, input int nsteps);
        step_t s;
        int n;
        n = 0;
        while (sq.size() > 0 && n < nsteps) begin
            s = sq.pop_front();
            check_cycle(s.st, s.mr, s.op, 1'b0, tag);
            if (s.last) exp_retired = (exp_retired + 1) % CNT_MOD;
            n++;
        end
    endtask

    initial begin
        reset = 1'b1; mem_ready = 1'b0; opcode = 4'd0;
        repeat (2) @(posedge clock);
        check_cycle(S_IDLE, 1'b0, 4'd0, 1'b1, "reset");
        check_cycle(S_IDLE, 1'b1, 4'd1, 1'b0, "idle");

        // Directed instructions
        add_instr(4'd1, 0, 0); run_queue("lw", 1000);
        add_instr(4'd0, 0, 0); run_queue("rtype", 1000);
        add_instr(4'd4, 3, 0); run_queue("fetch_wait_addi", 1000);
        add_instr(4'd2, 0, 2); run_queue("sw_wait", 1000);
        add_instr(4'd3, 0, 0); run_queue("beq", 1000);
        add_instr(4'd5, 0, 0); run_queue("jump", 1000);

        // Random legal instruction mix (counter wraps at 16)
        for (int k = 0; k < 30; k++) begin
            add_instr(4'($urandom_range(0, 5)), $urandom_range(0, 3), $urandom_range(0, 3));
            run_queue("random", 1000);
        end

        // Reset during a MEMREAD wait aborts the load
        add_instr(4'd1, 0, 4);
        run_queue("lw_abort", 5);
        sq.delete();
        check_cycle(S_MEMREAD, 1'b0, 4'd1, 1'b1, "abort_assert");
        exp_retired = 0;
        check_cycle(S_IDLE, 1'b0, 4'd1, 1'b1, "abort_idle");
        check_cycle(S_IDLE, 1'b1, 4'd1, 1'b0, "abort_release");

        for (int k = 0; k < 4; k++) begin
            add_instr(4'($urandom_range(0, 5)), $urandom_range(0, 2), $urandom_range(0, 2));
            run_queue("post_abort", 1000);
        end

        // Illegal opcode halts until reset
        add_instr(4'b1111, 0, 0); run_queue("illegal", 1000);
        for (int k = 0; k < 10; k++) check_cycle(S_HALT, rnd_bit(), 4'b1111, 1'b0, "halt_hold");
        check_cycle(S_HALT, 1'b0, 4'b1111, 1'b1, "halt_reset");
        exp_retired = 0;
        check_cycle(S_IDLE, 1'b0, 4'd0, 1'b1, "halt_idle");
        check_cycle(S_IDLE, 1'b1, 4'd0, 1'b0, "halt_release");
        check_cycle(S_FETCH, 1'b0, 4'd0, 1'b0, "restart_fetch");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
